// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) returns the grant.
interface rr_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   r;
  logic [N-1:0]   g;
  logic           gnt_valid;
  logic [IdW-1:0] gnt_id;

  modport master (
    output r,
    input  g,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  r,
    output g,
    output gnt_valid,
    output gnt_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant, optional grant holding
// bounded by a tenure limit, and a registered binary grant index.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD     = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic         clock,
  input logic         reset_n,
  rr_arbiter_if.slave arb
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned TenW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [IdW-1:0]  LastRst  = IdW'(N - 1);
  localparam logic [TenW-1:0] TenOne   = TenW'(1);
  localparam logic [TenW-1:0] TenLimit = TenW'(MAX_HOLD);
  // With unlimited holding the tenure value is never consulted, so park it at 1.
  localparam logic [TenW-1:0] TenSat   = (MAX_HOLD > 0) ? TenW'(MAX_HOLD) : TenW'(1);

  logic [N-1:0]    g_q, g_d;
  logic [IdW-1:0]  last_q, last_d;
  logic [IdW-1:0]  id_q, id_d;
  logic            valid_q, valid_d;
  logic [TenW-1:0] tenure_q, tenure_d;

  logic            held;
  logic            others;
  logic            expired;
  logic            keep;
  logic            found;
  logic [IdW-1:0]  win;
  logic [IdW-1:0]  idx;

  // Scan from the slot after the last grantee, wrapping, first request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IdW'((32'(last_q) + i + 32'd1) % N);
      if (!found && arb.r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    held    = |(arb.r & g_q);
    others  = |(arb.r & ~g_q);
    expired = 1'b0;
    if (MAX_HOLD != 0) begin
      expired = (tenure_q >= TenLimit) && others;
    end
    keep = (HOLD != 0) && (g_q != '0) && held && !expired;
  end

  always_comb begin
    g_d      = g_q;
    last_d   = last_q;
    id_d     = id_q;
    valid_d  = valid_q;
    tenure_d = tenure_q;
    if (keep) begin
      if (tenure_q != TenSat) begin
        tenure_d = tenure_q + TenOne;
      end
    end else if (found) begin
      g_d      = N'(1) << win;
      last_d   = win;
      id_d     = win;
      valid_d  = 1'b1;
      tenure_d = TenOne;
    end else begin
      g_d      = '0;
      id_d     = '0;
      valid_d  = 1'b0;
      tenure_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_q      <= '0;
      last_q   <= LastRst;
      id_q     <= '0;
      valid_q  <= 1'b0;
      tenure_q <= '0;
    end else begin
      g_q      <= g_d;
      last_q   <= last_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      tenure_q <= tenure_d;
    end
  end

  assign arb.g         = g_q;
  assign arb.gnt_valid = valid_q;
  assign arb.gnt_id    = id_q;

endmodule
